multiplicacao_matrizes_seq: RTL and testbench

Sequential, parametrised successor to the combinational int8 matrix multiplier. It multiplies two square signed matrices of N×N, where N is selectable from 2 to MAX_N. It uses one multiply-accumulate per clock under a start/busy/done handshake. Each result element is either saturated or wrapped to DATA_W bits, and a sticky overflow flag is kept. It sits behind the operations controller, which supplies the packed operands and reads back the packed result.

---
 rtl/multiplicacao_pkg.sv | 36 +++
 rtl/multiplicacao_matrizes_seq_saturador.sv | 33 +++
 rtl/multiplicacao_matrizes_seq.sv | 168 ++++++++++++++++
 tb/tb_multiplicacao_matrizes_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicacao_pkg.sv
// Shared types and helpers for the sequential matrix multiplier and its
// future vector siblings: FSM states, element range limits, packing helpers.
package multiplicacao_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_N_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int data_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int data_min(int w);
    return -(1 << (w - 1));
  endfunction

  localparam int DATA_MAX = data_max(DATA_W_DEF);
  localparam int DATA_MIN = data_min(DATA_W_DEF);

  // Bit offset of element (i,j) inside a row-major packed matrix bus.
  function automatic int idx(int i, int j, int max_n = MAX_N_DEF,
                             int data_w = DATA_W_DEF);
    return (i * max_n + j) * data_w;
  endfunction

  // matrix_size encodes N-2; anything beyond the supported maximum clamps.
  function automatic int decode_n(int size, int max_n = MAX_N_DEF);
    return (size + 2 > max_n) ? max_n : size + 2;
  endfunction

endpackage

// File: rtl/multiplicacao_matrizes_seq_saturador.sv
// Reduces a wide signed accumulator to DATA_W bits, either clamping or
// keeping the low bits, and flags values outside the signed DATA_W range.
module saturador
  import multiplicacao_pkg::*;
#(
  parameter int ACC_W  = 19,
  parameter int DATA_W = 8
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     sat_en,
  output logic        [DATA_W-1:0] y,
  output logic                     ovf
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(data_max(DATA_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(data_min(DATA_W));

  logic above;
  logic below;

  always_comb begin
    above = (acc > HI);
    below = (acc < LO);
    ovf   = above | below;
    y     = acc[DATA_W-1:0];
    if (sat_en && above) begin
      y = HI[DATA_W-1:0];
    end else if (sat_en && below) begin
      y = LO[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/multiplicacao_matrizes_seq.sv
// Sequential N x N signed matrix multiplier: one multiply-accumulate per
// clock, start/busy/done handshake, per-element saturate or wrap.
//
//   state   | meaning
//   IDLE    | waiting for start; C and overflow_flag held
//   COMPUTE | one MAC per cycle over i, j, k
//   DONE    | one-cycle done pulse, start ignored
module multiplicacao_matrizes_seq
  import multiplicacao_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_N  = MAX_N_DEF,
  parameter int SIZE_W = $clog2(MAX_N - 1),
  parameter int ACC_W  = 2 * DATA_W + $clog2(MAX_N)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            sat_en,
  input  logic [SIZE_W-1:0]               matrix_size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   A,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   B,
  output logic                            busy,
  output logic                            done,
  output logic [MAX_N*MAX_N*DATA_W-1:0]   C,
  output logic                            overflow_flag
);

  localparam int IDX_W = (MAX_N > 2) ? $clog2(MAX_N) : 1;
  localparam int VEC_W = MAX_N * MAX_N * DATA_W;
  localparam int OFF_W = $clog2(VEC_W);

  state_t state_q;
  state_t state_d;

  logic [VEC_W-1:0]        a_q;
  logic [VEC_W-1:0]        b_q;
  logic [VEC_W-1:0]        c_q;
  logic                    ovf_q;
  logic                    sat_q;
  logic [IDX_W-1:0]        last_q;
  logic [IDX_W-1:0]        i_q;
  logic [IDX_W-1:0]        j_q;
  logic [IDX_W-1:0]        k_q;
  logic signed [ACC_W-1:0] acc_q;

  logic [OFF_W-1:0]         a_off;
  logic [OFF_W-1:0]         b_off;
  logic [OFF_W-1:0]         c_off;
  logic signed [DATA_W-1:0] a_el;
  logic signed [DATA_W-1:0] b_el;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0]        elem;
  logic                     elem_ovf;
  logic                     k_last;
  logic                     j_last;
  logic                     i_last;
  logic                     final_mac;

  always_comb begin
    a_off    = OFF_W'(idx(int'(i_q), int'(k_q), MAX_N, DATA_W));
    b_off    = OFF_W'(idx(int'(k_q), int'(j_q), MAX_N, DATA_W));
    c_off    = OFF_W'(idx(int'(i_q), int'(j_q), MAX_N, DATA_W));
    a_el     = a_q[a_off +: DATA_W];
    b_el     = b_q[b_off +: DATA_W];
    prod     = a_el * b_el;
    prod_ext = ACC_W'(prod);
    acc_next = acc_q + prod_ext;
    k_last   = (k_q == last_q);
    j_last   = (j_q == last_q);
    i_last   = (i_q == last_q);
    final_mac = k_last && j_last && i_last;
  end

  saturador #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_saturador (
    .acc    (acc_next),
    .sat_en (sat_q),
    .y      (elem),
    .ovf    (elem_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (final_mac) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      sat_q  <= 1'b0;
      last_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            sat_q  <= sat_en;
            last_q <= IDX_W'(decode_n(int'(matrix_size), MAX_N) - 1);
            c_q    <= '0;
            ovf_q  <= 1'b0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
          end
        end
        COMPUTE: begin
          if (k_last) begin
            c_q[c_off +: DATA_W] <= elem;
            if (elem_ovf) ovf_q <= 1'b1;
            acc_q <= '0;
            k_q   <= '0;
            if (j_last) begin
              j_q <= '0;
              i_q <= i_last ? '0 : i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= acc_next;
            k_q   <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign C             = c_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_multiplicacao_matrizes_seq.sv
// Directed bench for the sequential matrix multiplier: hand-computed results
// for 2x2 to 5x5, saturate and wrap, handshake, mid-run reset, back-to-back.
module tb_multiplicacao_matrizes_seq;

  localparam int DW = 8;
  localparam int MN = 5;
  localparam int VW = MN * MN * DW;

  typedef logic [VW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sat_en;
  logic [1:0] matrix_size;
  vec_t       a_v;
  vec_t       b_v;
  logic       busy;
  logic       done;
  vec_t       c;
  logic       ovf;
  vec_t       exp_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiplicacao_matrizes_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .sat_en        (sat_en),
    .matrix_size   (matrix_size),
    .A             (a_v),
    .B             (b_v),
    .busy          (busy),
    .done          (done),
    .C             (c),
    .overflow_flag (ovf)
  );

  task automatic check(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t put(vec_t v, int i, int j, int val);
    logic [31:0] t;
    t = val;
    v[(i*MN+j)*DW +: DW] = t[DW-1:0];
    return v;
  endfunction

  function automatic logic [DW-1:0] el(vec_t v, int i, int j);
    return v[(i*MN+j)*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] b8(int val);
    logic [31:0] t;
    t = val;
    return t[DW-1:0];
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // that follows the done pulse, so a back-to-back start can go out at once.
  task automatic run(input logic [1:0] msize, input logic sat, input int exp_lat,
                     input logic glitch, input string tag);
    int cyc;
    int busy_cnt;
    matrix_size = msize;
    sat_en      = sat;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_c_cleared"}, c, '0);
    check({tag, "_ovf_cleared"}, ovf, 0);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 300) begin
      if (busy) busy_cnt++;
      cyc++;
      if (glitch && cyc == 3) begin
        start = 1'b1;
        a_v   = ~a_v;
      end
      if (glitch && cyc == 4) begin
        start = 1'b0;
        a_v   = ~a_v;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_done_high"}, done, 1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic load_2x2();
    a_v = '0; b_v = '0; exp_c = '0;
    a_v = put(a_v, 0, 0, 1); a_v = put(a_v, 0, 1, 2);
    a_v = put(a_v, 1, 0, 3); a_v = put(a_v, 1, 1, 4);
    b_v = put(b_v, 0, 0, 5); b_v = put(b_v, 0, 1, 6);
    b_v = put(b_v, 1, 0, 7); b_v = put(b_v, 1, 1, 8);
    exp_c = put(exp_c, 0, 0, 19); exp_c = put(exp_c, 0, 1, 22);
    exp_c = put(exp_c, 1, 0, 43); exp_c = put(exp_c, 1, 1, 50);
  endtask

  task automatic load_3x3();
    a_v = '0; b_v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a_v = put(a_v, i, j, i*3 + j + 1);
        b_v = put(b_v, i, j, 9 - (i*3 + j));
      end
  endtask

  int e33 [9];
  int a55 [25];
  int r55 [5];
  int done_cnt;

  initial begin
    rst_n = 1'b0; start = 1'b0; sat_en = 1'b0; matrix_size = '0;
    a_v = '0; b_v = '0; exp_c = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_c", c, '0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_2x2();
    run(2'd0, 1'b1, 8, 1'b0, "t2x2");
    check("t2x2_c", c, exp_c);
    check("t2x2_ovf", ovf, 0);

    load_3x3();
    e33 = '{30, 24, 18, 84, 69, 54, 127, 114, 90};
    exp_c = '0;
    for (int n = 0; n < 9; n++) exp_c = put(exp_c, n / 3, n % 3, e33[n]);
    run(2'd1, 1'b1, 27, 1'b0, "t3x3_sat");
    check("t3x3_sat_c", c, exp_c);
    check("t3x3_sat_ovf", ovf, 1);

    exp_c = put(exp_c, 2, 0, -118);
    run(2'd1, 1'b0, 27, 1'b0, "t3x3_wrap");
    check("t3x3_wrap_c", c, exp_c);
    check("t3x3_wrap_c20", el(c, 2, 0), b8(-118));
    check("t3x3_wrap_ovf", ovf, 1);

    a_v = '0; b_v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_v = put(a_v, i, j, -(i*4 + j + 1));
        b_v = put(b_v, i, j, i*4 + j + 1);
      end
    run(2'd2, 1'b1, 64, 1'b0, "t4x4");
    check("t4x4_c00", el(c, 0, 0), b8(-90));
    check("t4x4_c03", el(c, 0, 3), b8(-120));
    check("t4x4_c10", el(c, 1, 0), b8(-128));
    check("t4x4_c04_outside", el(c, 0, 4), 0);
    check("t4x4_c44_outside", el(c, 4, 4), 0);
    check("t4x4_ovf", ovf, 1);

    a55 = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110, 120, -128, -64, -32,
            -16, -8, -4, -2, -1, 1, 2, 3, 4, 5};
    r55 = '{127, 127, 6, -31, 15};
    a_v = '0; b_v = '0; exp_c = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        a_v   = put(a_v, i, j, a55[i*5 + j]);
        b_v   = put(b_v, i, j, 1);
        exp_c = put(exp_c, i, j, r55[i]);
      end
    run(2'd3, 1'b1, 125, 1'b0, "t5x5");
    check("t5x5_c", c, exp_c);
    check("t5x5_ovf", ovf, 1);

    // start goes out in the cycle right after done; stale overflow must clear
    load_2x2();
    run(2'd0, 1'b1, 8, 1'b0, "b2b");
    check("b2b_c", c, exp_c);
    check("b2b_ovf", ovf, 0);

    @(negedge clk);
    load_2x2();
    run(2'd0, 1'b1, 8, 1'b1, "glitch");
    check("glitch_c", c, exp_c);

    @(negedge clk);
    load_3x3();
    matrix_size = 2'd1; sat_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_progress_c00", el(c, 0, 0), 30);
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_c", c, '0);
    check("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle_busy", busy, 0);

    load_2x2();
    run(2'd0, 1'b1, 8, 1'b0, "after_rst");
    check("after_rst_c", c, exp_c);
    check("after_rst_ovf", ovf, 0);

    repeat (5) @(negedge clk);
    check("hold_c", c, exp_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
